instruction_fetch: RTL and testbench

Instruction fetch unit that supplies 32-bit RISC-V instructions to `controlUnit`. It maintains the program counter and issues single-outstanding word reads to instruction memory. Fetched words and their PCs are buffered in a 2-entry FIFO and handed to the decoder over a valid/ready handshake. A redirect input (branch/jump target) flushes the buffer and discards any in-flight memory response.

---
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch.sv | 87 ++++++++
 tb/tb_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory read port and decoder handshake.
// master = fetch unit, slave = memory/decoder/branch environment.
interface instruction_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instruction, instr_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC + single-outstanding word reads, 2-entry {pc,instr} FIFO to the decoder.
// Redirect flushes the FIFO and drains any in-flight response.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus_io
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q  [2];
  logic [31:0] fifo_ins_q [2];
  logic        redir, push, pop;

  always_comb begin
    redir    = bus_io.redirect_valid;
    pop      = (cnt_q != 2'd0) && bus_io.instr_ready && !redir;
    push     = (state_q == WAIT) && bus_io.imem_rvalid && !redir;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    state_d  = state_q;
    pc_d     = pc_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (bus_io.imem_rvalid) begin
                 pc_d    = pc_q + 32'd4;
                 state_d = (cnt_d < 2'd2) ? REQ : HOLD;
               end
      HOLD:    if (cnt_d < 2'd2) state_d = REQ;
      DRAIN:   if (bus_io.imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // Redirect wins over everything; go through DRAIN only if a response is still owed.
    if (redir) begin
      pc_d     = {bus_io.redirect_pc[31:2], 2'b00};
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      if (state_q == REQ ||
          ((state_q == WAIT || state_q == DRAIN) && !bus_io.imem_rvalid))
        state_d = DRAIN;
      else
        state_d = REQ;
    end
    // Address register only moves when a new request is about to issue.
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= pc_q;
      fifo_ins_q[wr_ptr_q] <= bus_io.imem_rdata;
    end
  end

  assign bus_io.imem_req    = (state_q == REQ);
  assign bus_io.imem_addr   = addr_q;
  assign bus_io.instr_valid = (cnt_q != 2'd0);
  assign bus_io.instruction = (cnt_q != 2'd0) ? fifo_ins_q[rd_ptr_q] : NOP_INSTR;
  assign bus_io.instr_pc    = (cnt_q != 2'd0) ? fifo_pc_q[rd_ptr_q]  : 32'h0;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked against
// an in-order PC/instruction stream model.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [31:0] seed;

  instruction_fetch_if bus ();
  instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a ^ seed) * 32'h9E37_79B1;
  endfunction

  // Memory: answers each request lat cycles later; forgets pending work on reset.
  logic        m_pend = 1'b0;
  logic [31:0] m_addr;
  int          m_cnt;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1'b0;
      bus.imem_rvalid = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      if (m_pend) begin
        if (m_cnt <= 1) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = memf(m_addr);
          m_pend = 1'b0;
        end else m_cnt = m_cnt - 1;
      end
      if (bus.imem_req) begin
        m_pend = 1'b1; m_addr = bus.imem_addr; m_cnt = lat;
      end
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #2;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", bus.imem_addr, RST_PC); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
    checks++; if (bus.instruction !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", bus.instruction, NOP); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.instr_pc); end
  endtask

  task automatic test_first_fetch();
    lat = 1;
    do_reset();
    bus.instr_ready = 1'b1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ff_c0_req got %b exp 0", bus.imem_req); end
    cyc();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL ff_c1_req got %b/%h exp 1/00000100", bus.imem_req, bus.imem_addr); end
    cyc();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL ff_c2 got valid %b req %b exp 0/0", bus.instr_valid, bus.imem_req); end
    cyc();
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ff_c3_valid got %b exp 1", bus.instr_valid); end
    checks++; if (bus.instruction !== 32'h0050_0093 || bus.instr_pc !== 32'h100) begin errors++; $display("FAIL ff_c3_data got %h@%h exp 00500093@00000100", bus.instruction, bus.instr_pc); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin errors++; $display("FAIL ff_next_req got %b/%h exp 1/00000104", bus.imem_req, bus.imem_addr); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL bp_req0 got %b/%h exp 1/00000000", bus.imem_req, bus.imem_addr); end
    repeat (4) cyc();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_stall_req cyc %0d got %b exp 0", i, bus.imem_req); end
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instruction !== memf(32'h0)) begin
        errors++; $display("FAIL bp_head cyc %0d got %b %h@%h exp 1 %h@00000000", i, bus.instr_valid, bus.instruction, bus.instr_pc, memf(32'h0)); end
      if (i < 4) cyc();
    end
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_req got %b/%h exp 1/00000008", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.instr_pc !== 32'h4 || bus.instruction !== memf(32'h4)) begin errors++; $display("FAIL bp_head_after_pop got %h@%h exp %h@00000004", bus.instruction, bus.instr_pc, memf(32'h4)); end
  endtask

  task automatic test_redirect_wait();
    int req_cyc;
    lat = 3;
    do_reset();
    bus.instr_ready = 1'b1;
    cyc(); // c1 REQ 0x100
    cyc(); // c2 WAIT
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h2002;
    cyc();
    bus.redirect_valid = 1'b0;
    req_cyc = -1;
    for (int c = 3; c < 30 && req_cyc < 0; c++) begin
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rw_flush cyc %0d got valid %b exp 0", c, bus.instr_valid); end
      if (bus.imem_req === 1'b1) begin
        req_cyc = c;
        checks++; if (bus.imem_addr !== 32'h2000) begin errors++; $display("FAIL rw_addr got %h exp 00002000", bus.imem_addr); end
      end else cyc();
    end
    checks++; if (req_cyc != 5) begin errors++; $display("FAIL rw_req_cycle got %0d exp 5", req_cyc); end
    for (int c = 0; c < 20 && bus.instr_valid !== 1'b1; c++) cyc();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h2000 || bus.instruction !== memf(32'h2000)) begin
      errors++; $display("FAIL rw_first got %b %h@%h exp 1 %h@00002000", bus.instr_valid, bus.instruction, bus.instr_pc, memf(32'h2000)); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_redirect_rvalid_pop();
    lat = 1;
    do_reset();
    repeat (3) cyc(); // c3: head 0x100, REQ 0x104
    cyc();            // c4: WAIT with rvalid
    checks++; if (bus.instr_valid !== 1'b1 || bus.imem_rvalid !== 1'b1) begin errors++; $display("FAIL rr_setup got valid %b rvalid %b exp 1/1", bus.instr_valid, bus.imem_rvalid); end
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3000;
    cyc();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rr_flush got %b exp 0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL rr_req got %b/%h exp 1/00003000", bus.imem_req, bus.imem_addr); end
    cyc(); cyc();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h3000 || bus.instruction !== memf(32'h3000)) begin
      errors++; $display("FAIL rr_first got %b %h@%h exp 1 %h@00003000", bus.instr_valid, bus.instruction, bus.instr_pc, memf(32'h3000)); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [2];
    int n;
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0;
    lat = 2;
    do_reset();
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      if (bus.instr_valid === 1'b1) begin
        checks++; if (bus.instr_pc !== exp_pc[n] || bus.instruction !== memf(exp_pc[n])) begin
          errors++; $display("FAIL wrap_%0d got %h@%h exp %h@%h", n, bus.instruction, bus.instr_pc, memf(exp_pc[n]), exp_pc[n]); end
        n++;
      end
      cyc();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", n); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int c;
    lat = 3;
    do_reset();
    c = 0;
    while (c < 30 && !(bus.imem_req === 1'b1 && bus.imem_addr === 32'h104)) begin cyc(); c++; end
    checks++; if (c >= 30) begin errors++; $display("FAIL ar_reach got timeout exp req 00000104"); end
    cyc(); // WAIT on 0x104 with 0x100 buffered
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ar_setup got valid %b exp 1", bus.instr_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC) begin errors++; $display("FAIL ar_req got %b/%h exp 0/%h", bus.imem_req, bus.imem_addr, RST_PC); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.instruction !== NOP || bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL ar_out got %b %h@%h exp 0 %h@00000000", bus.instr_valid, bus.instruction, bus.instr_pc, NOP); end
    do_reset();
    bus.instr_ready = 1'b1;
    for (c = 0; c < 30 && bus.instr_valid !== 1'b1; c++) cyc();
    checks++; if (bus.instr_pc !== 32'h100 || bus.instruction !== memf(32'h100)) begin
      errors++; $display("FAIL ar_restart got %h@%h exp %h@00000100", bus.instruction, bus.instr_pc, memf(32'h100)); end
    bus.instr_ready = 1'b0;
  endtask

  // Reference: delivered stream is pc, pc+4, ... restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic prev_req;
    int outst, pops;
    logic rdy, rd;
    logic [31:0] rpc;
    lat = 1;
    do_reset();
    exp_pc = RST_PC; prev_req = 1'b0; outst = 0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.imem_rvalid === 1'b1) outst--;
      if (bus.imem_req === 1'b1) begin
        checks++; if (prev_req || outst != 0) begin errors++; $display("FAIL rnd_req cyc %0d got prev %b outst %0d exp 0/0", c, prev_req, outst); end
        outst++;
      end
      prev_req = bus.imem_req;
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      lat = $urandom_range(1, 4);
      if (bus.instr_valid === 1'b1) begin
        if (rdy && !rd) begin
          checks++; if (bus.instr_pc !== exp_pc || bus.instruction !== memf(exp_pc)) begin
            errors++; $display("FAIL rnd_pop cyc %0d got %h@%h exp %h@%h", c, bus.instruction, bus.instr_pc, memf(exp_pc), exp_pc); end
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end else begin
        checks++; if (bus.instruction !== NOP || bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rnd_empty cyc %0d got %h@%h exp %h@00000000", c, bus.instruction, bus.instr_pc, NOP); end
      end
      if (rd) exp_pc = {rpc[31:2], 2'b00};
      bus.instr_ready = rdy;
      bus.redirect_valid = rd;
      bus.redirect_pc = rpc;
      cyc();
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    checks++; if (pops < 200) begin errors++; $display("FAIL rnd_progress got %0d pops exp >=200", pops); end
  endtask

  initial begin
    seed = $urandom;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
